vending_multi: RTL

Parametrised multi-product successor to the single-soda vending controller. Accepts nickel/dime/quarter pulses into a saturating credit register, and vends one of `N_PROD` products at runtime-programmable prices. Per-product stock is tracked. Change or a cancel refund is returned coin-by-coin, greedily. Sits under the board-level top in place of the fixed-price controller.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/vending_multi_change_dispenser.sv | 62 ++++++
 rtl/vending_multi.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_e;

  localparam int unsigned NICKEL_C  = 32'd5;
  localparam int unsigned DIME_C    = 32'd10;
  localparam int unsigned QUARTER_C = 32'd25;

  // Total value in cents of the coin pulses seen in one cycle.
  function automatic int unsigned coin_sum(input logic n, input logic d, input logic q);
    int unsigned sum;
    sum = 32'd0;
    if (n) sum = sum + NICKEL_C; else sum = sum + 32'd0;
    if (d) sum = sum + DIME_C;   else sum = sum + 32'd0;
    if (q) sum = sum + QUARTER_C; else sum = sum + 32'd0;
    return sum;
  endfunction

endpackage

// File: rtl/vending_multi_change_dispenser.sv
// Greedy change dispenser: holds a remainder and pays it out one coin per
// cycle (quarter, then dime, then nickel). A load can issue its first coin in
// the same cycle so a refund starts paying immediately.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         issue_i,
  output coin_e        coin_o,
  output logic [W-1:0] rem_next_o,
  output logic         done_o
);

  logic [W-1:0] rem_q, rem_d, src_s;
  coin_e        coin_q, coin_d;

  // Pick the largest coin that fits the remainder being paid out.
  always_comb begin
    coin_d = NONE;
    if (load_i) begin
      src_s = load_val_i;
    end else begin
      src_s = rem_q;
    end
    rem_d = src_s;
    if (!issue_i) begin
      coin_d = NONE;
    end else if (src_s >= W'(QUARTER_C)) begin
      coin_d = QUARTER;
      rem_d  = src_s - W'(QUARTER_C);
    end else if (src_s >= W'(DIME_C)) begin
      coin_d = DIME;
      rem_d  = src_s - W'(DIME_C);
    end else if (src_s != '0) begin
      coin_d = NICKEL;
      rem_d  = src_s - W'(NICKEL_C);
    end else begin
      coin_d = NONE;
    end
  end

  // Remainder and dispensed-coin registers; reset discards unpaid change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      coin_q <= NONE;
    end else begin
      rem_q  <= rem_d;
      coin_q <= coin_d;
    end
  end

  assign coin_o     = coin_q;
  assign rem_next_o = rem_d;
  assign done_o     = (rem_q == '0);

endmodule

// File: rtl/vending_multi.sv
// Multi-product vending controller: saturating coin credit, runtime price
// table, per-product stock, greedy change and cancel refunds.
module vending_multi
  import vending_pkg::*;
#(
  parameter  int N_PROD     = 4,
  parameter  int CREDIT_W   = 8,
  parameter  int CREDIT_MAX = 200,
  parameter  int STOCK_W    = 4,
  parameter  int STOCK_MAX  = 10,
  localparam int ID_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nickel,
  input  logic                       dime,
  input  logic                       quarter,
  input  logic                       sel_valid,
  input  logic [ID_W-1:0]            sel_id,
  input  logic                       cancel,
  input  logic                       restock,
  input  logic [N_PROD*CREDIT_W-1:0] prices,
  output logic                       soda,
  output logic [ID_W-1:0]            soda_id,
  output logic [1:0]                 change,
  output logic                       coin_reject,
  output logic                       sold_out,
  output logic [CREDIT_W-1:0]        credit,
  output logic                       busy
);

  localparam int SUM_W = CREDIT_W + 2;
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [N_PROD];
  logic [STOCK_W-1:0]  stock_d [N_PROD];

  logic [CREDIT_W-1:0] price_s;
  logic [STOCK_W-1:0]  stock_sel_s;
  logic                sel_hit_s, idle_like_s, any_coin_s;
  logic                cancel_acc_s, sel_acc_s, sel_empty_s, coin_take_s;
  logic [SUM_W-1:0]    coin_sum_s, credit_plus_s;

  logic                load_s, issue_s, done_s;
  logic [CREDIT_W-1:0] load_val_s, rem_next_s;
  coin_e               coin_s;

  logic                soda_q, soda_d, reject_q, reject_d, sold_out_q, sold_out_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     soda_id_q, soda_id_d;
  logic [CREDIT_W-1:0] credit_out_q, credit_out_d;

  // Look up price and stock of the selected product; out-of-range ids miss.
  always_comb begin
    price_s     = '0;
    stock_sel_s = '0;
    sel_hit_s   = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_id == ID_W'(i)) begin
        price_s     = prices[i*CREDIT_W +: CREDIT_W];
        stock_sel_s = stock_q[i];
        sel_hit_s   = 1'b1;
      end else begin
        sel_hit_s   = sel_hit_s;
      end
    end
  end

  // Decode which request wins this cycle: cancel, then select, then coins.
  always_comb begin
    idle_like_s   = (state_q == IDLE) || (state_q == CREDIT);
    any_coin_s    = nickel | dime | quarter;
    coin_sum_s    = SUM_W'(coin_sum(nickel, dime, quarter));
    credit_plus_s = {2'b00, credit_q} + coin_sum_s;
    cancel_acc_s  = cancel && (state_q == CREDIT);
    sel_empty_s   = idle_like_s && !cancel_acc_s && sel_valid && sel_hit_s &&
                    (stock_sel_s == '0);
    sel_acc_s     = idle_like_s && !cancel_acc_s && sel_valid && sel_hit_s &&
                    (stock_sel_s != '0) && (credit_q >= price_s);
    coin_take_s   = idle_like_s && any_coin_s && !cancel_acc_s && !sel_acc_s &&
                    (credit_plus_s <= SUM_W'(CREDIT_MAX));
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, CREDIT: begin
        if (cancel_acc_s) begin
          state_d = CHANGE;
        end else if (sel_acc_s) begin
          state_d = VEND;
        end else if (coin_take_s) begin
          state_d = CREDIT;
        end else begin
          state_d = state_q;
        end
      end
      VEND: begin
        if (done_s) begin
          state_d = IDLE;
        end else begin
          state_d = CHANGE;
        end
      end
      CHANGE: begin
        if (done_s) begin
          state_d = IDLE;
        end else begin
          state_d = CHANGE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit accumulation, stock bookkeeping and dispenser control.
  always_comb begin
    stock_d  = stock_q;
    credit_d = credit_q;
    if (cancel_acc_s || sel_acc_s) begin
      credit_d = '0;
    end else if (coin_take_s) begin
      credit_d = credit_plus_s[CREDIT_W-1:0];
    end else begin
      credit_d = credit_q;
    end
    load_s  = cancel_acc_s || sel_acc_s;
    issue_s = cancel_acc_s || (state_q == VEND) || (state_q == CHANGE);
    if (cancel_acc_s) begin
      load_val_s = credit_q;
    end else begin
      load_val_s = credit_q - price_s;
    end
    for (int i = 0; i < N_PROD; i++) begin
      if (restock) begin
        stock_d[i] = STOCK_FULL;
      end else if (sel_acc_s && (sel_id == ID_W'(i))) begin
        stock_d[i] = stock_q[i] - STOCK_ONE;
      end else begin
        stock_d[i] = stock_q[i];
      end
    end
  end

  // Output next values; credit shows the remainder while busy.
  always_comb begin
    soda_d     = sel_acc_s;
    reject_d   = any_coin_s && !coin_take_s;
    sold_out_d = sel_empty_s;
    busy_d     = (state_d == VEND) || (state_d == CHANGE);
    if (sel_acc_s) begin
      soda_id_d = sel_id;
    end else begin
      soda_id_d = '0;
    end
    if (busy_d) begin
      credit_out_d = rem_next_s;
    end else begin
      credit_out_d = credit_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Credit and stock registers; reset refills every product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q <= '0;
      for (int i = 0; i < N_PROD; i++) begin
        stock_q[i] <= STOCK_FULL;
      end
    end else begin
      credit_q <= credit_d;
      stock_q  <= stock_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      soda_q       <= 1'b0;
      soda_id_q    <= '0;
      reject_q     <= 1'b0;
      sold_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      credit_out_q <= '0;
    end else begin
      soda_q       <= soda_d;
      soda_id_q    <= soda_id_d;
      reject_q     <= reject_d;
      sold_out_q   <= sold_out_d;
      busy_q       <= busy_d;
      credit_out_q <= credit_out_d;
    end
  end

  change_dispenser #(
    .W (CREDIT_W)
  ) u_change (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .issue_i    (issue_s),
    .coin_o     (coin_s),
    .rem_next_o (rem_next_s),
    .done_o     (done_s)
  );

  assign soda        = soda_q;
  assign soda_id     = soda_id_q;
  assign change      = coin_s;
  assign coin_reject = reject_q;
  assign sold_out    = sold_out_q;
  assign credit      = credit_out_q;
  assign busy        = busy_q;

endmodule
